// File: rtl/square_gen.sv
// square_gen: iterative squarer.
// Computes n*n by summing the first n odd numbers (1+3+5+...), one odd
// number per clock cycle, under a start/busy/done handshake.
//
// Ports:
//   clk    - system clock, all state updates on the rising edge
//   clr    - synchronous active-high reset
//   start  - request a new computation (sampled only while idle)
//   n      - operand, latched on the accepted start edge
//   sq     - result register, updated only when the computation completes
//   busy   - high while computing and during the done cycle
//   done   - one-cycle completion pulse
//   odd_q  - current odd increment (observation)
//   cnt_q  - remaining iterations (observation)
module square_gen #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [W-1:0]     n,
  output logic [2*W-1:0]   sq,
  output logic             busy,
  output logic             done,
  output logic [W:0]       odd_q,
  output logic [W-1:0]     cnt_q
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [W:0]     ODD_FIRST = {{W{1'b0}}, 1'b1};
  localparam logic [W:0]     ODD_STEP  = {{(W-1){1'b0}}, 2'b10};
  localparam logic [W-1:0]   CNT_ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]   CNT_ZERO  = {W{1'b0}};
  localparam logic [2*W-1:0] ACC_ZERO  = {(2*W){1'b0}};

  state_t           state_q, state_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [2*W-1:0]   sq_q, sq_d;
  logic [W:0]       odd_d;
  logic [W-1:0]     cnt_d;

  // State and data-path registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      acc_q   <= ACC_ZERO;
      sq_q    <= ACC_ZERO;
      odd_q   <= ODD_FIRST;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sq_q    <= sq_d;
      odd_q   <= odd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and data-path update logic; every register holds by default.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sq_d    = sq_q;
    odd_d   = odd_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = n;
          acc_d   = ACC_ZERO;
          odd_d   = ODD_FIRST;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q != CNT_ZERO) begin
          // odd_q is zero-extended to the accumulator width; the sum of the
          // first (2^W-1) odd numbers fits in 2*W bits, so no overflow.
          acc_d   = acc_q + {{(W-1){1'b0}}, odd_q};
          odd_d   = odd_q + ODD_STEP;
          cnt_d   = cnt_q - CNT_ONE;
          state_d = ST_RUN;
        end else begin
          sq_d    = acc_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are the result register and decodes of the registered state.
  assign sq   = sq_q;
  assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_square_gen.sv
// Directed self-checking bench for square_gen (W=4).
module tb_square_gen;

  localparam int W = 4;

  logic             clk;
  logic             clr;
  logic             start;
  logic [W-1:0]     n;
  logic [2*W-1:0]   sq;
  logic             busy;
  logic             done;
  logic [W:0]       odd_q;
  logic [W-1:0]     cnt_q;

  int total;
  int passed;
  int cyc;
  int last_sq;

  square_gen #(.W(W)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .n     (n),
    .sq    (sq),
    .busy  (busy),
    .done  (done),
    .odd_q (odd_q),
    .cnt_q (cnt_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance past one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Tick until done is seen; c is the cycle count at that edge, -1 on timeout.
  task automatic wait_done(input int budget, output int c);
    c = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done === 1'b1) begin
        c = cyc;
        break;
      end
    end
    check("wait_done_timeout", (c >= 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // One complete computation with a single-cycle start pulse.
  task automatic run_one(input int nv);
    int lat;
    n     = nv[W-1:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_cnt", {28'd0, cnt_q}, nv);
    check("start_odd", {27'd0, odd_q}, 32'd1);
    check("sq_hold_run", {24'd0, sq}, last_sq);
    lat = 0;
    while (done !== 1'b1 && lat < nv + 5) begin
      tick();
      lat++;
    end
    check("latency", lat, nv + 1);
    check("sq_result", {24'd0, sq}, nv * nv);
    check("odd_final", {27'd0, odd_q}, 2 * nv + 1);
    tick();
    check("done_width", {31'd0, done}, 32'd0);
    check("busy_drop", {31'd0, busy}, 32'd0);
    last_sq = nv * nv;
  endtask

  initial begin
    int c1, c2, c3, dcount;
    total   = 0;
    passed  = 0;
    cyc     = 0;
    last_sq = 0;
    clr     = 1'b1;
    start   = 1'b0;
    n       = 4'd0;

    // Reset state.
    tick();
    clr = 1'b0;
    check("rst_sq", {24'd0, sq}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_odd", {27'd0, odd_q}, 32'd1);
    check("rst_cnt", {28'd0, cnt_q}, 32'd0);

    // n=10, stepping odd_q and cnt_q each iteration.
    n     = 4'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("n10_busy_k", {31'd0, busy}, 32'd1);
    for (int j = 1; j <= 10; j++) begin
      tick();
      check("n10_odd_step", {27'd0, odd_q}, 2 * j + 1);
      check("n10_cnt_step", {28'd0, cnt_q}, 10 - j);
      check("n10_no_done", {31'd0, done}, 32'd0);
    end
    tick();
    check("n10_done", {31'd0, done}, 32'd1);
    check("n10_sq", {24'd0, sq}, 32'd100);
    check("n10_busy_done", {31'd0, busy}, 32'd1);
    tick();
    check("n10_busy_drop", {31'd0, busy}, 32'd0);
    check("n10_done_drop", {31'd0, done}, 32'd0);
    last_sq = 100;

    // Boundaries.
    run_one(0);
    run_one(15);

    // start held high with n=3; n changes to 5 mid-RUN.
    n     = 4'd3;
    start = 1'b1;
    tick();
    wait_done(10, c1);
    check("hold_sq1", {24'd0, sq}, 32'd9);
    tick();
    check("hold_idle_busy", {31'd0, busy}, 32'd0);
    tick();
    check("hold_restart_busy", {31'd0, busy}, 32'd1);
    n = 4'd5;
    wait_done(10, c2);
    check("hold_period", c2 - c1, 32'd6);
    check("hold_sq2", {24'd0, sq}, 32'd9);
    wait_done(12, c3);
    check("hold_period_n5", c3 - c2, 32'd8);
    check("hold_sq3", {24'd0, sq}, 32'd25);
    start = 1'b0;
    tick();
    check("hold_end_busy", {31'd0, busy}, 32'd0);
    last_sq = 25;

    // clr mid-RUN after 5 iterations of n=12.
    n     = 4'd12;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    check("mid_cnt", {28'd0, cnt_q}, 32'd7);
    check("mid_odd", {27'd0, odd_q}, 32'd11);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_sq", {24'd0, sq}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_done", {31'd0, done}, 32'd0);
    check("clr_odd", {27'd0, odd_q}, 32'd1);
    check("clr_cnt", {28'd0, cnt_q}, 32'd0);
    dcount = 0;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    check("clr_no_done", dcount, 32'd0);
    last_sq = 0;
    run_one(7);

    // Exhaustive n=0..15.
    for (int k = 0; k < 16; k++) run_one(k);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
